dcache_controller: RTL and testbench
====================================

# dcache_controller

Direct-mapped, write-back, write-allocate L1 data cache controller between the MEM stage and off-chip data memory. Serves MEM-stage loads and stores from a 16-line internal store. On a miss it runs a writeback/refill sequence and holds `cpu_stall_o` high. `cpu_stall_o` is the `mem_stall` that freezes the EX/MEM register and the rest of the pipeline.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; index width is log2(`LINES`).
- `LINE_BITS`, 256: line width (32 bytes, 8 words).

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `cpu_addr_i`  in  32  byte address from EX/MEM ALU result; word-aligned.
- `cpu_data_i`  in  32  store data from EX/MEM rs2 data.
- `cpu_MemRead_i`  in  1  load request.
- `cpu_MemWrite_i`  in  1  store request.
- `cpu_data_o`  out  32  load data; valid while a hit is reported.
- `cpu_stall_o`  out  1  pipeline stall (`mem_stall`).
- `mem_enable_o`  out  1  off-chip request; level.
- `mem_write_o`  out  1  1 = line write, 0 = line read.
- `mem_addr_o`  out  32  line address, low 5 bits zero.
- `mem_data_o`  out  256  writeback line.
- `mem_data_i`  in  256  refill line.
- `mem_ack_i`  in  1  one-cycle completion pulse from memory.

## Operation
- Address split: offset = `addr[4:0]`, word = `addr[4:2]`, index = `addr[8:5]`, tag = `addr[31:9]` (23 bits).
- Per-line metadata: valid, dirty, tag. Per-line data: 256 bits.
- `req` = `cpu_MemRead_i | cpu_MemWrite_i`. If both inputs are high, the access is handled as a store.
- `hit` = `req` & valid[index] & tag match. `hit` is combinational.
- FSM states:
  - IDLE:
    - `req & hit`: no stall. A load drives the selected word on `cpu_data_o`. A store merges `cpu_data_i` into the selected word at the edge and sets dirty.
    - `req & !hit & dirty[index]`: go to WRITEBACK.
    - `req & !hit & !dirty[index]`: go to ALLOCATE.
  - WRITEBACK:
    - Drive `mem_enable_o`=1 and `mem_write_o`=1.
    - `mem_addr_o` = {stored tag, index, 5'b0}; `mem_data_o` = stored line.
    - On `mem_ack_i`, go to ALLOCATE.
  - ALLOCATE:
    - Drive `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o` = {`cpu_addr_i[31:5]`, 5'b0}.
    - On `mem_ack_i`, capture `mem_data_i` into the line. Set valid=1, dirty=0, tag=new tag. Go to REFILLED.
  - REFILLED: go to IDLE. The access now hits and completes there; a store then sets dirty.
- `cpu_stall_o` = (IDLE & `req` & !`hit`) | (state != IDLE).
- Memory request outputs are registered, as are state, metadata and data. `mem_enable_o` stays high until the cycle `mem_ack_i` is sampled, then drops in the following cycle.
- `mem_ack_i` outside WRITEBACK/ALLOCATE is ignored.
- The CPU address and data are held stable by the stall and are not latched.

## Timing
- Reset values:
  - state IDLE.
  - All valid and dirty bits cleared.
  - `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
  - `cpu_data_o`=0 and `cpu_stall_o`=0 with no request.
  - Data and tag contents are don't-care.
- Reset asserted mid-miss aborts the transaction immediately. No partial line is written and the line stays invalid.
- Hit latency: 0 cycles; data is valid in the same cycle, with no stall.
- Clean miss: stall for 1 (IDLE) + ALLOCATE cycles up to and including the ack + 1 (REFILLED) cycles. The access completes in the following IDLE cycle.
- Dirty miss: adds the WRITEBACK cycles up to and including its ack.
- Ack in the first cycle of WRITEBACK or ALLOCATE is legal.
- Back-to-back hits to any index complete at one per cycle.
- Writeback uses the old tag, not the requesting tag. Index and word fields never wrap.

## Structure
- Shared package `dcache_pkg`:
  - widths: `TAG_W`=23, `IDX_W`=4, `WORD_SEL_W`=3.
  - `LINE_BITS`.
  - FSM state enum {IDLE, WRITEBACK, ALLOCATE, REFILLED}.
- Sub-module `dcache_sram`:
  - storage arrays: metadata and data.
  - one write port with full-line or single-word write.
  - asynchronous read.
- The controller holds only the FSM, hit logic and memory-request registers.

## Test plan
- After reset, load 0x0000_0040 -> stall. ALLOCATE with `mem_addr_o`=0x40, `mem_write_o`=0. Memory acks after 10 cycles with a line whose word 0 is 0xDEADBEEF -> `cpu_data_o`=0xDEADBEEF, stall drops after REFILLED.
- Load 0x44 immediately after the previous refill -> 0-cycle hit, no memory request, word 1 returned.
- Store 0x1234_5678 to 0x40 (hit), then load 0x0000_0240 (same index 2, new tag):
  - Expect WRITEBACK to 0x40 with word 0 = 0x12345678, then ALLOCATE 0x240.
  - The line ends with dirty=0.
- Reset pulsed low during ALLOCATE before ack -> outputs return to reset values. The next load to the same address misses again.
- `mem_ack_i` pulsed in IDLE, and MemRead+MemWrite both high on a hit:
  - The stray ack has no effect.
  - The dual request behaves as a store and sets dirty.
- Stores to 8 consecutive words of one line, then eviction -> writeback line carries all 8 values in word order.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared widths and FSM encoding for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int TAG_W      = 23;
  localparam int IDX_W      = 4;
  localparam int WORD_SEL_W = 3;
  localparam int LINE_BITS  = 256;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    REFILLED  = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_sram.sv
// Cache line store: valid/dirty/tag metadata plus line data, one write port
// (full-line refill or single-word store) and asynchronous read of one index.
module dcache_sram #(
  parameter int LINES     = 16,
  parameter int LINE_BITS = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             line_we,
  input  logic                             word_we,
  input  logic [dcache_pkg::IDX_W-1:0]      idx,
  input  logic [dcache_pkg::TAG_W-1:0]      wr_tag,
  input  logic [dcache_pkg::WORD_SEL_W-1:0] word_sel,
  input  logic [31:0]                      word_data,
  input  logic [LINE_BITS-1:0]             line_data,
  output logic                             rd_valid,
  output logic                             rd_dirty,
  output logic [dcache_pkg::TAG_W-1:0]      rd_tag,
  output logic [LINE_BITS-1:0]             rd_line
);
  import dcache_pkg::*;

  logic [LINES-1:0]     valid_r;
  logic [LINES-1:0]     dirty_r;
  logic [TAG_W-1:0]     tag_r  [LINES];
  logic [LINE_BITS-1:0] data_r [LINES];

  // Valid/dirty bits: cleared by reset, set clean on refill, marked dirty on store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (line_we) begin
      valid_r[idx] <= 1'b1;
      dirty_r[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_r[idx] <= 1'b1;
    end
  end

  // Tag array: contents are meaningless until valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_r[idx] <= wr_tag;
    end
  end

  // Data array: whole-line refill takes priority over a single-word merge.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_r[idx] <= line_data;
    end else if (word_we) begin
      data_r[idx][{word_sel, 5'b00000} +: 32] <= word_data;
    end
  end

  assign rd_valid = valid_r[idx];
  assign rd_dirty = dirty_r[idx];
  assign rd_tag   = tag_r[idx];
  assign rd_line  = data_r[idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache controller: hit logic,
// miss FSM (writeback then refill) and registered off-chip request outputs.
module dcache_controller #(
  parameter int LINES     = 16,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);
  import dcache_pkg::*;

  state_e                state_r;
  state_e                state_nxt_s;
  logic                  mem_enable_r;
  logic                  mem_write_r;
  logic [31:0]           mem_addr_r;
  logic [LINE_BITS-1:0]  mem_data_r;

  logic [TAG_W-1:0]      tag_s;
  logic [IDX_W-1:0]      idx_s;
  logic [WORD_SEL_W-1:0] word_s;
  logic                  req_s;
  logic                  hit_s;
  logic                  miss_s;
  logic                  line_we_s;
  logic                  word_we_s;
  logic                  rd_valid_s;
  logic                  rd_dirty_s;
  logic [TAG_W-1:0]      rd_tag_s;
  logic [LINE_BITS-1:0]  rd_line_s;
  logic [1:0]            unused_offset_s;

  assign tag_s           = cpu_addr_i[31:9];
  assign idx_s           = cpu_addr_i[8:5];
  assign word_s          = cpu_addr_i[4:2];
  assign unused_offset_s = cpu_addr_i[1:0];

  assign req_s  = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit_s  = req_s & rd_valid_s & (rd_tag_s == tag_s);
  assign miss_s = req_s & ~hit_s;

  // Refill writes the whole line on the ack; a store hit (including a
  // read+write request) merges one word while the FSM is idle.
  assign line_we_s = (state_r == ALLOCATE) & mem_ack_i;
  assign word_we_s = (state_r == IDLE) & hit_s & cpu_MemWrite_i;

  dcache_sram #(
    .LINES     (LINES),
    .LINE_BITS (LINE_BITS)
  ) u_sram (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .line_we   (line_we_s),
    .word_we   (word_we_s),
    .idx       (idx_s),
    .wr_tag    (tag_s),
    .word_sel  (word_s),
    .word_data (cpu_data_i),
    .line_data (mem_data_i),
    .rd_valid  (rd_valid_s),
    .rd_dirty  (rd_dirty_s),
    .rd_tag    (rd_tag_s),
    .rd_line   (rd_line_s)
  );

  // Next-state logic of the miss sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (miss_s) begin
          state_nxt_s = rd_dirty_s ? WRITEBACK : ALLOCATE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_nxt_s = ALLOCATE;
        end else begin
          state_nxt_s = WRITEBACK;
        end
      end
      ALLOCATE: begin
        if (mem_ack_i) begin
          state_nxt_s = REFILLED;
        end else begin
          state_nxt_s = ALLOCATE;
        end
      end
      REFILLED: state_nxt_s = IDLE;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Memory request registers, loaded in the same edge as the state they belong to;
  // the writeback request carries the old tag and line of the victim.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_enable_r <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_data_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (miss_s) begin
            mem_enable_r <= 1'b1;
            if (rd_dirty_s) begin
              mem_write_r <= 1'b1;
              mem_addr_r  <= {rd_tag_s, idx_s, 5'b00000};
              mem_data_r  <= rd_line_s;
            end else begin
              mem_write_r <= 1'b0;
              mem_addr_r  <= {cpu_addr_i[31:5], 5'b00000};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            mem_write_r <= 1'b0;
            mem_addr_r  <= {cpu_addr_i[31:5], 5'b00000};
          end
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            mem_enable_r <= 1'b0;
            mem_write_r  <= 1'b0;
          end
        end
        default: begin
          mem_enable_r <= mem_enable_r;
        end
      endcase
    end
  end

  assign mem_enable_o = mem_enable_r;
  assign mem_write_o  = mem_write_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_data_o   = mem_data_r;

  assign cpu_stall_o = ((state_r == IDLE) & miss_s) | (state_r != IDLE);
  assign cpu_data_o  = (hit_s & cpu_MemRead_i & ~cpu_MemWrite_i)
                       ? rd_line_s[{word_s, 5'b00000} +: 32] : 32'd0;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a hand-driven memory.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic         got_wr;
  logic [31:0]  got_addr;
  logic [255:0] got_data;
  logic [255:0] l1, l2, l3, l4, l5;

  dcache_controller #(.LINES(16), .LINE_BITS(256)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base, input logic [31:0] w0);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    l[31:0] = w0;
    return l;
  endfunction

  // Wait (bounded) for a request, capture it, ack after `delay` cycles.
  task automatic serve(input int delay, input logic [255:0] line,
                       output logic wr, output logic [31:0] addr, output logic [255:0] wdata);
    int cnt = 0;
    while (!mem_enable_o && cnt < 50) begin
      @(negedge clk_i);
      cnt++;
    end
    check("mem_req_seen", {255'd0, mem_enable_o}, 256'd1);
    wr    = mem_write_o;
    addr  = mem_addr_o;
    wdata = mem_data_o;
    repeat (delay) @(negedge clk_i);
    mem_data_i = line;
    mem_ack_i  = 1'b1;
    @(negedge clk_i);
    mem_ack_i  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    l1 = make_line(32'hA000_0000, 32'hDEAD_BEEF);
    l2 = make_line(32'hB000_0000, 32'h0BAD_F00D);
    l3 = make_line(32'hC000_0000, 32'h1234_5678);
    l4 = make_line(32'hD000_0000, 32'h4444_4444);
    l5 = make_line(32'hE000_0000, 32'h5555_5555);
    rst_i = 1'b0; cpu_addr_i = 32'd0; cpu_data_i = 32'd0;
    cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
    mem_data_i = 256'd0; mem_ack_i = 1'b0;
    #1;
    check("rst_enable", {255'd0, mem_enable_o}, 256'd0);
    check("rst_write",  {255'd0, mem_write_o},  256'd0);
    check("rst_addr",   {224'd0, mem_addr_o},   256'd0);
    check("rst_mdata",  mem_data_o,             256'd0);
    check("rst_stall",  {255'd0, cpu_stall_o},  256'd0);
    check("rst_cdata",  {224'd0, cpu_data_o},   256'd0);
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b1;

    // Clean miss on 0x40, ack after 10 cycles.
    @(negedge clk_i);
    cpu_addr_i = 32'h0000_0040; cpu_MemRead_i = 1'b1; #1;
    check("t1_miss_stall", {255'd0, cpu_stall_o}, 256'd1);
    check("t1_no_req_yet", {255'd0, mem_enable_o}, 256'd0);
    @(negedge clk_i);
    serve(10, l1, got_wr, got_addr, got_data);
    check("t1_alloc_wr",   {255'd0, got_wr}, 256'd0);
    check("t1_alloc_addr", {224'd0, got_addr}, 256'h40);
    check("t1_refilled_stall", {255'd0, cpu_stall_o}, 256'd1);
    check("t1_enable_drop",    {255'd0, mem_enable_o}, 256'd0);
    @(negedge clk_i);
    check("t1_stall_done", {255'd0, cpu_stall_o}, 256'd0);
    check("t1_data",       {224'd0, cpu_data_o}, 256'hDEADBEEF);

    // Hit on word 1 of the same line.
    cpu_addr_i = 32'h0000_0044; #1;
    check("t2_hit_stall", {255'd0, cpu_stall_o}, 256'd0);
    check("t2_hit_data",  {224'd0, cpu_data_o}, 256'hA0000001);
    check("t2_no_req",    {255'd0, mem_enable_o}, 256'd0);

    // Store hit, then conflicting load forces writeback of old tag.
    cpu_addr_i = 32'h0000_0040; cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b1;
    cpu_data_i = 32'h1234_5678; #1;
    check("t3_store_stall", {255'd0, cpu_stall_o}, 256'd0);
    @(negedge clk_i);
    cpu_MemWrite_i = 1'b0; cpu_MemRead_i = 1'b1; cpu_addr_i = 32'h0000_0240; #1;
    check("t3_miss_stall", {255'd0, cpu_stall_o}, 256'd1);
    @(negedge clk_i);
    serve(3, 256'd0, got_wr, got_addr, got_data);
    check("t3_wb_wr",    {255'd0, got_wr}, 256'd1);
    check("t3_wb_addr",  {224'd0, got_addr}, 256'h40);
    check("t3_wb_word0", {224'd0, got_data[31:0]}, 256'h12345678);
    check("t3_wb_word1", {224'd0, got_data[63:32]}, 256'hA0000001);
    serve(2, l2, got_wr, got_addr, got_data);
    check("t3_alloc_wr",   {255'd0, got_wr}, 256'd0);
    check("t3_alloc_addr", {224'd0, got_addr}, 256'h240);
    check("t3_refilled_stall", {255'd0, cpu_stall_o}, 256'd1);
    @(negedge clk_i);
    check("t3_stall_done", {255'd0, cpu_stall_o}, 256'd0);
    check("t3_data", {224'd0, cpu_data_o}, 256'h0BADF00D);
    // Evicting the refilled line must not write back: it is clean.
    cpu_addr_i = 32'h0000_0040; #1;
    check("t3_clean_stall", {255'd0, cpu_stall_o}, 256'd1);
    @(negedge clk_i);
    check("t3_clean_enable", {255'd0, mem_enable_o}, 256'd1);
    check("t3_clean_nowb",   {255'd0, mem_write_o}, 256'd0);
    check("t3_clean_addr",   {224'd0, mem_addr_o}, 256'h40);
    serve(0, l3, got_wr, got_addr, got_data);
    @(negedge clk_i);
    check("t3_reload_data", {224'd0, cpu_data_o}, 256'h12345678);

    // Reset during ALLOCATE aborts the miss.
    cpu_addr_i = 32'h0000_0080;
    @(negedge clk_i);
    check("t4_alloc_enable", {255'd0, mem_enable_o}, 256'd1);
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0; cpu_MemRead_i = 1'b0; #1;
    check("t4_rst_enable", {255'd0, mem_enable_o}, 256'd0);
    check("t4_rst_write",  {255'd0, mem_write_o},  256'd0);
    check("t4_rst_addr",   {224'd0, mem_addr_o},   256'd0);
    check("t4_rst_mdata",  mem_data_o,             256'd0);
    check("t4_rst_stall",  {255'd0, cpu_stall_o},  256'd0);
    @(negedge clk_i);
    rst_i = 1'b1; cpu_MemRead_i = 1'b1; #1;
    check("t4_miss_again", {255'd0, cpu_stall_o}, 256'd1);
    @(negedge clk_i);
    check("t4_alloc_wr",   {255'd0, mem_write_o}, 256'd0);
    check("t4_alloc_addr", {224'd0, mem_addr_o}, 256'h80);
    serve(1, l4, got_wr, got_addr, got_data);
    @(negedge clk_i);
    check("t4_data", {224'd0, cpu_data_o}, 256'h44444444);

    // Stray ack in IDLE, then read+write treated as a store.
    cpu_MemRead_i = 1'b0; mem_ack_i = 1'b1; mem_data_i = {256{1'b1}};
    @(negedge clk_i);
    mem_ack_i = 1'b0; #1;
    check("t5_stray_enable", {255'd0, mem_enable_o}, 256'd0);
    check("t5_stray_stall",  {255'd0, cpu_stall_o}, 256'd0);
    cpu_MemRead_i = 1'b1; #1;
    check("t5_line_intact", {224'd0, cpu_data_o}, 256'h44444444);
    cpu_addr_i = 32'h0000_0084; cpu_MemWrite_i = 1'b1; cpu_data_i = 32'hCAFE_F00D; #1;
    check("t5_dual_stall", {255'd0, cpu_stall_o}, 256'd0);
    @(negedge clk_i);
    cpu_MemWrite_i = 1'b0; #1;
    check("t5_dual_data", {224'd0, cpu_data_o}, 256'hCAFEF00D);
    cpu_addr_i = 32'h0000_0280; #1;
    check("t5_evict_stall", {255'd0, cpu_stall_o}, 256'd1);
    @(negedge clk_i);
    check("t5_dirty_wb", {255'd0, mem_write_o}, 256'd1);
    serve(0, 256'd0, got_wr, got_addr, got_data);
    check("t5_wb_addr",  {224'd0, got_addr}, 256'h80);
    check("t5_wb_word0", {224'd0, got_data[31:0]}, 256'h44444444);
    check("t5_wb_word1", {224'd0, got_data[63:32]}, 256'hCAFEF00D);
    serve(0, l5, got_wr, got_addr, got_data);
    check("t5_alloc_addr", {224'd0, got_addr}, 256'h280);
    @(negedge clk_i);
    check("t5_new_data", {224'd0, cpu_data_o}, 256'h55555555);

    // Fill all 8 words of index 6 with back-to-back store hits, then evict.
    cpu_addr_i = 32'h0000_00C0;
    @(negedge clk_i);
    serve(0, l1, got_wr, got_addr, got_data);
    check("t6_alloc_addr", {224'd0, got_addr}, 256'hC0);
    @(negedge clk_i);
    cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cpu_addr_i = 32'h0000_00C0 + 32'(4 * i);
      cpu_data_i = 32'h5A00_0000 + 32'(i);
      #1;
      check("t6_store_stall", {255'd0, cpu_stall_o}, 256'd0);
      @(negedge clk_i);
    end
    cpu_MemWrite_i = 1'b0; cpu_MemRead_i = 1'b1; cpu_addr_i = 32'h0000_02C0;
    @(negedge clk_i);
    serve(0, 256'd0, got_wr, got_addr, got_data);
    check("t6_wb_wr",   {255'd0, got_wr}, 256'd1);
    check("t6_wb_addr", {224'd0, got_addr}, 256'hC0);
    for (int i = 0; i < 8; i++) begin
      check("t6_wb_word", {224'd0, got_data[i*32 +: 32]}, {224'd0, 32'h5A00_0000 + 32'(i)});
    end
    serve(0, l2, got_wr, got_addr, got_data);
    check("t6_alloc2_addr", {224'd0, got_addr}, 256'h2C0);
    @(negedge clk_i);
    check("t6_final_data", {224'd0, cpu_data_o}, 256'h0BADF00D);
    cpu_MemRead_i = 1'b0;
    @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
